// File: rtl/submaster_rd_xfer_if.sv
// AXI read-channel bundle (AR + R) between the submaster read engine and the
// fabric. The master modport belongs to the engine.
interface submaster_rd_xfer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [ID_W-1:0]   arid;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arid, arvalid, rready,
    input  arready, rdata, rresp, rid, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arid, arvalid, rready,
    output arready, rdata, rresp, rid, rlast, rvalid
  );
endinterface

// File: rtl/submaster_rd_xfer.sv
// Execution stage of the 8-way submaster read arbiter: one granted burst at a
// time, AR issue, R beat steering to the owner, then a done/err pulse.
module submaster_rd_xfer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          grant,
  input  logic [8*ADDR_W-1:0] req_addr,
  input  logic [8*LEN_W-1:0]  req_len,
  output logic [7:0]          xfer_done,
  output logic [7:0]          rd_err,
  output logic [7:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  submaster_rd_xfer_if.master axi
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_q;
  logic [2:0]        sel_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [ID_W-1:0]   arid_q;
  logic              arvalid_q, rready_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  timer_q;
  logic              err_q;
  logic [7:0]        xfer_done_q, rd_err_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_last_q;

  logic [2:0] gidx;
  logic       beat, beat_err, tmo, err_d;
  logic [7:0] sel_oh;

  // Lowest set grant bit wins; the arbiter should only ever drive one.
  always_comb begin
    gidx = '0;
    for (int i = 7; i >= 0; i--)
      if (grant[i]) gidx = 3'(i);
  end

  always_comb begin
    sel_oh   = 8'd1 << sel_q;
    beat     = (state_q == DATA) && axi.rvalid && rready_q;
    beat_err = (axi.rresp != 2'b00) || (axi.rid != arid_q) ||
               (axi.rlast && (cnt_q != arlen_q)) ||
               (!axi.rlast && (cnt_q == arlen_q));
    tmo      = (timer_q == TMR_W'(TIMEOUT - 1));
    err_d    = err_q || (beat && beat_err) || tmo;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arid_q      <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cnt_q       <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      xfer_done_q <= '0;
      rd_err_q    <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      xfer_done_q <= '0;
      rd_err_q    <= '0;
      rd_valid_q  <= '0;
      if (beat) begin
        rd_valid_q <= sel_oh;
        rd_data_q  <= axi.rdata;
        rd_last_q  <= axi.rlast;
        cnt_q      <= cnt_q + 1'b1;
      end
      if ((state_q == ADDR || state_q == DATA) && timer_q != '1)
        timer_q <= timer_q + 1'b1;

      case (state_q)
        IDLE: if (|grant) begin
          sel_q     <= gidx;
          araddr_q  <= req_addr[gidx*ADDR_W +: ADDR_W];
          arlen_q   <= req_len[gidx*LEN_W +: LEN_W];
          arid_q    <= ID_W'(gidx);
          timer_q   <= '0;
          cnt_q     <= '0;
          err_q     <= 1'b0;
          arvalid_q <= 1'b1;
          state_q   <= ADDR;
        end
        ADDR: begin
          if (tmo) begin
            arvalid_q   <= 1'b0;
            err_q       <= 1'b1;
            xfer_done_q <= sel_oh;
            rd_err_q    <= sel_oh;
            state_q     <= DONE;
          end else if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          err_q <= err_d;
          // A beat landing on the timeout cycle is still forwarded.
          if ((beat && axi.rlast) || tmo) begin
            rready_q    <= 1'b0;
            xfer_done_q <= sel_oh;
            rd_err_q    <= err_d ? sel_oh : 8'd0;
            state_q     <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xfer_done   = xfer_done_q;
  assign rd_err      = rd_err_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arid    = arid_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
endmodule

// File: tb/tb_submaster_rd_xfer.sv
// Randomized bench for submaster_rd_xfer: an open-loop AXI slave driver, an
// output monitor, and a burst-level expectation model.
module tb_submaster_rd_xfer;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 4;
  localparam int TIMEOUT = 300;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [7:0]          grant = '0;
  logic [8*ADDR_W-1:0] req_addr = '0;
  logic [8*LEN_W-1:0]  req_len = '0;
  logic [7:0]          xfer_done, rd_err, rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_last;

  submaster_rd_xfer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) axi_if ();

  submaster_rd_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W),
                      .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .grant(grant), .req_addr(req_addr), .req_len(req_len),
    .xfer_done(xfer_done), .rd_err(rd_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .axi(axi_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor results
  logic [7:0]  m_vld[$];
  logic [31:0] m_dat[$];
  bit          m_lst[$];
  logic [31:0] exp_dat[$];
  int m_dcnt, m_arv, m_stray;
  logic [7:0] m_dvec, m_evec;
  bit m_dlast;

  task automatic monitor();
    int cyc, post;
    cyc = 0; post = -1;
    m_vld.delete(); m_dat.delete(); m_lst.delete();
    m_dcnt = 0; m_arv = 0; m_stray = 0; m_dvec = '0; m_evec = '0; m_dlast = 0;
    while (cyc < TIMEOUT + 100 && post != 0) begin
      @(negedge clk);
      cyc++;
      if (axi_if.arvalid) m_arv++;
      if (rd_valid != 0) begin
        m_vld.push_back(rd_valid); m_dat.push_back(rd_data); m_lst.push_back(rd_last);
      end
      if (xfer_done != 0) begin
        m_dcnt++; m_dvec |= xfer_done; m_evec |= rd_err;
        if (rd_valid != 0) m_dlast = 1;
        if (post < 0) post = 3;
      end else if (rd_err != 0) m_stray++;
      if (post > 0) post--;
    end
  endtask

  // Open-loop slave: AR accepted after ar_dly ADDR cycles, then nb beats with
  // random gaps, rlast only on the final beat.
  task automatic driver(input int idx, input logic [31:0] addr, input int len, input int nb,
                        input int bad_beat, input bit bad_id, input int ar_dly,
                        input int gap_max, input bit no_ar);
    logic [31:0] d;
    for (int k = 0; k <= ar_dly; k++) begin
      @(negedge clk);
      grant = (k < ar_dly) ? 8'($urandom_range(1, 255)) : 8'h00;
      chk("araddr", axi_if.araddr, addr);
      if (k == 0) begin
        chk("arlen", axi_if.arlen, len[7:0]);
        chk("arid", axi_if.arid, idx);
      end
      axi_if.arready = (k == ar_dly) && !no_ar;
    end
    @(negedge clk);
    axi_if.arready = 1'b0;
    grant = '0;
    if (!no_ar) begin
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, gap_max)) begin
          axi_if.rvalid = 1'b0; axi_if.rdata = $urandom; axi_if.rlast = 1'b1;
          @(negedge clk);
        end
        d = $urandom;
        exp_dat.push_back(d);
        axi_if.rvalid = 1'b1;
        axi_if.rdata  = d;
        axi_if.rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
        axi_if.rid    = ID_W'(bad_id ? (idx ^ 1) : idx);
        axi_if.rlast  = (b == nb - 1);
        @(negedge clk);
      end
      axi_if.rvalid = 1'b0;
      axi_if.rlast  = 1'b0;
    end
  endtask

  task automatic run_burst(input int idx, input logic [31:0] addr, input int len, input int nb,
                           input int bad_beat, input bit bad_id, input int ar_dly,
                           input int gap_max, input bit no_ar);
    bit exp_err;
    int exp_n, g;
    exp_dat.delete();
    for (int s = 0; s < 8; s++) begin
      req_addr[s*ADDR_W +: ADDR_W] = $urandom;
      req_len[s*LEN_W +: LEN_W]    = 8'($urandom);
    end
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_len[idx*LEN_W +: LEN_W]    = 8'(len);
    // extra higher-index bits must lose to the lowest set bit
    g = (1 << idx) | ($urandom_range(0, 255) & ~((2 << idx) - 1));
    @(negedge clk);
    grant = 8'(g);
    fork
      driver(idx, addr, len, nb, bad_beat, bad_id, ar_dly, gap_max, no_ar);
      monitor();
    join
    exp_n   = no_ar ? 0 : nb;
    exp_err = no_ar || (bad_beat >= 0) || bad_id || (nb != len + 1);
    chk("beats", m_vld.size(), exp_n);
    for (int i = 0; i < m_vld.size() && i < exp_n; i++) begin
      chk("rd_valid", m_vld[i], 8'd1 << idx);
      chk("rd_data", m_dat[i], exp_dat[i]);
      chk("rd_last", m_lst[i], i == exp_n - 1);
    end
    chk("done_cnt", m_dcnt, 1);
    chk("done_vec", m_dvec, 8'd1 << idx);
    chk("err_vec", m_evec, exp_err ? (8'd1 << idx) : 8'd0);
    chk("err_stray", m_stray, 0);
    chk("done_w_last", m_dlast, !no_ar);
    chk("arv_cycles", m_arv, no_ar ? TIMEOUT : ar_dly + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, axi_if.arvalid, 0);
    chk({tag, "_rready"}, axi_if.rready, 0);
    chk({tag, "_done"}, xfer_done, 0);
    chk({tag, "_err"}, rd_err, 0);
    chk({tag, "_vld"}, rd_valid, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_last"}, rd_last, 0);
  endtask

  initial begin
    int len, nb;
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 0;
    axi_if.rresp = 0; axi_if.rid = 0; axi_if.rlast = 0;
    #12;
    chk_all_zero("reset");
    chk("reset_araddr", axi_if.araddr, 0);
    chk("reset_arid", axi_if.arid, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // single beat, then the test-plan directed cases
    run_burst(2, 32'h1000, 0, 1, -1, 0, 0, 0, 0);
    run_burst(7, 32'h8000_0040, 3, 4, -1, 0, 3, 2, 0);
    run_burst(0, 32'h2000, 1, 2, 0, 0, 0, 1, 0);
    run_burst(5, 32'h3000, 3, 2, -1, 0, 1, 1, 0);
    run_burst(4, 32'h4000, 0, 2, -1, 0, 0, 0, 0);
    run_burst(6, 32'h5000, 2, 3, -1, 1, 0, 0, 0);
    run_burst(1, 32'h6000, 255, 256, -1, 0, 0, 0, 0);
    run_burst(3, 32'h7000, 5, 6, -1, 0, 0, 0, 1);
    run_burst(3, 32'h7100, 1, 2, -1, 0, 1, 1, 0);

    // reset in the middle of a 4-beat burst
    @(negedge clk);
    req_addr[3*ADDR_W +: ADDR_W] = 32'h9000;
    req_len[3*LEN_W +: LEN_W] = 8'd3;
    grant = 8'h08;
    @(negedge clk);
    grant = 8'h00; axi_if.arready = 1'b1;
    @(negedge clk);
    axi_if.arready = 1'b0; axi_if.rvalid = 1'b1; axi_if.rdata = 32'h1234_5678;
    axi_if.rid = 4'd3; axi_if.rresp = 2'b00; axi_if.rlast = 1'b0;
    @(negedge clk);
    axi_if.rvalid = 1'b0;
    chk("mid_vld", rd_valid, 8'h08);
    chk("mid_rready", axi_if.rready, 1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("mid_rst");
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", xfer_done, 0);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_burst(3, 32'h9100, 2, 3, -1, 0, 1, 1, 0);

    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(0, 7);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : len + 1;
      run_burst($urandom_range(0, 7), $urandom, len, nb,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1,
                $urandom_range(0, 6) == 0, $urandom_range(0, 4), 2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/submaster_rd_xfer.md
Name: submaster_rd_xfer

Overview:
- Downstream execution stage of the 8-way submaster read arbiter.
- On a one-cycle grant pulse, it captures the granted submaster's address and length, then issues one AXI read burst on AR.
- It collects the R beats and steers them to that submaster.
- It then pulses that submaster's xfer_done, which returns the arbiter from its WAIT state to IDLE.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI read data width.
- LEN_W, 8, burst length field width (AXI arlen; beats = len+1).
- ID_W, 4, AXI ID width (must be >= 3).
- TIMEOUT, 1024, maximum cycles spent in ADDR+DATA before a forced abort.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- grant  in  8  one-hot grant pulses from the arbiter (bit n = submaster n).
- req_addr  in  8*ADDR_W  per-submaster start address, slice n = bits [n*ADDR_W +: ADDR_W].
- req_len  in  8*LEN_W  per-submaster burst length minus 1, slice n.
- xfer_done  out  8  one-cycle completion pulse to submaster n and the arbiter.
- rd_err  out  8  error flag, valid only in the xfer_done cycle.
- rd_valid  out  8  one-hot data strobe to the owning submaster.
- rd_data  out  DATA_W  read data, shared bus.
- rd_last  out  1  last beat, qualified by any rd_valid bit.
- araddr  out  ADDR_W  AXI AR address.
- arlen  out  LEN_W  AXI AR length.
- arid  out  ID_W  AXI AR ID.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rdata  in  DATA_W  AXI R data.
- rresp  in  2  AXI R response.
- rid  in  ID_W  AXI R ID.
- rlast  in  1  AXI R last.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- Reset (asynchronous, resetn low): state = IDLE.
  - All outputs 0.
  - sel, len, beat counter, timer and error flag cleared.
- Reset mid-burst: arvalid/rready drop immediately; no xfer_done is issued.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On grant != 0, sel = index of the lowest set bit. This is the lowest-index-wins rule; the arbiter only ever drives one bit.
  - Latch araddr = req_addr[sel], arlen = req_len[sel], arid = sel zero-extended.
  - Clear timer, beat counter and error flag; go to ADDR.
  - grant is ignored in every other state.
- ADDR:
  - arvalid = 1; araddr, arlen and arid are held stable.
  - On arvalid & arready, arvalid deasserts in the same cycle and the next state is DATA. Minimum latency is grant to arvalid = 1 cycle.
- DATA:
  - rready = 1.
  - Each beat (rvalid & rready) registers rd_data = rdata, rd_valid = 1 << sel and rd_last = rlast, all visible on the next cycle. Data latency is 1 cycle.
  - rd_valid is 0 in any cycle without a beat. The beat counter increments per beat.
  - Error flag is set (sticky) by any of:
    - rresp != 2'b00;
    - rid != arid;
    - a beat arriving with rlast while count != arlen;
    - a beat with count == arlen and rlast = 0.
  - Transition to DONE occurs only on a beat with rlast = 1. Excess beats without rlast continue to be forwarded and keep the error flag set.
- DONE (one cycle):
  - xfer_done[sel] = 1 and rd_err[sel] = error flag; the last beat's rd_valid coincides with this cycle.
  - Next state is IDLE.
  - The earliest next grant is accepted in the IDLE cycle after DONE. Back-to-back bursts cost 2 idle cycles minimum.
- Timeout:
  - The timer counts every cycle in ADDR and DATA.
  - On reaching TIMEOUT-1: error flag set, arvalid/rready drop, go to DONE.
  - Late R beats are then ignored (rready = 0) until the next burst.
- Width rules:
  - The beat counter is LEN_W bits; arlen = all-ones (256 beats) must not wrap before the compare.
  - The timer is clog2(TIMEOUT) bits and saturates.
- Outputs in IDLE: arvalid = rready = 0, xfer_done = rd_err = rd_valid = 0.

Test Plan:
- Single beat: grant = 8'h04, req_addr[2] = 0x1000, req_len[2] = 0; rdata = 0xCAFE with rlast, OKAY.
  -> arvalid next cycle with araddr = 0x1000, arlen = 0, arid = 2.
  -> rd_valid = 8'h04, rd_data = 0xCAFE.
  -> xfer_done = 8'h04, rd_err = 0.
- 4-beat burst to submaster 7 with arready delayed 3 cycles and rvalid gaps.
  -> araddr is stable during the stall.
  -> rd_valid = 8'h80 exactly 4 times, data order preserved, rd_last on the 4th.
  -> a single xfer_done[7] pulse.
- Error response: 2-beat burst with beat 1 rresp = 2'b10 -> both beats forwarded, xfer_done[0] = 1 with rd_err[0] = 1.
- Length mismatch: arlen = 3 but rlast on beat 2 -> DONE after beat 2, rd_err set. Also arlen = 0 with rlast on beat 2 -> 2 beats forwarded, rd_err set.
- Timeout: arready held low -> after TIMEOUT cycles arvalid = 0 and xfer_done with rd_err pulse; a subsequent grant starts cleanly.
- Reset mid-DATA: assert resetn = 0 after beat 1 of 4 -> all outputs 0 immediately, no xfer_done. Then a new grant after reset completes normally.
